// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a showahead FIFO in bursts of BURST_LEN words (or a
// short burst after TIMEOUT non-empty idle cycles) onto a valid/ready stream,
// marking the final word of each burst with last_o.
// Ports:
//   clk_i, srst_i               clock, synchronous active-high reset
//   fifo_q_i, fifo_empty_i,     showahead FIFO head word, empty flag, fill level
//   fifo_usedw_i
//   fifo_rdreq_o                FIFO pop (combinational from state and inputs)
//   data_o, valid_o, last_o     output stream, fed from a 2-entry buffer
//   ready_i                     consumer ready
//   busy_o                      burst in progress or buffered words pending
module fifo_burst_reader #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int unsigned CW = AWIDTH + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BURST_LEN_W = CW'(BURST_LEN);
  localparam logic [TW-1:0] TMO_LAST    = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     tmo_q;
  logic [DWIDTH-1:0] buf_data_q [2];
  logic [1:0]        buf_last_q;
  logic [1:0]        buf_cnt_q;

  logic full_start;
  logic tmo_start;
  logic pop;
  logic pop_last;
  logic pull;
  logic wr_idx;

  // Burst start conditions and per-pop bookkeeping
  always_comb begin
    full_start = (fifo_usedw_i >= BURST_LEN_W);
    tmo_start  = (TIMEOUT != 0) && !fifo_empty_i && (tmo_q == TMO_LAST);
    pop        = fifo_rdreq_o;
    pop_last   = ((cnt_q + CW'(1)) == len_q);
    pull       = valid_o && ready_i;
    // A pop lands behind whatever survives this cycle's transfer
    wr_idx     = (buf_cnt_q == 2'd1) && !pull;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_start || tmo_start) state_d = BURST;
      BURST:   if (pop && pop_last)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; pops are suppressed while reset is asserted
  always_comb begin
    fifo_rdreq_o = 1'b0;
    if ((state_q == BURST) && !fifo_empty_i && (buf_cnt_q < 2'd2) && !srst_i) begin
      fifo_rdreq_o = 1'b1;
    end
    valid_o = (buf_cnt_q != 2'd0);
    busy_o  = (state_q == BURST) || (buf_cnt_q != 2'd0);
    data_o  = buf_data_q[0];
    last_o  = buf_last_q[0];
  end

  // Burst length, pop counter and idle timeout counter
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      len_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
    end else if (state_q == IDLE) begin
      if (full_start) begin
        len_q <= BURST_LEN_W;
        tmo_q <= '0;
      end else if (tmo_start) begin
        len_q <= fifo_usedw_i;
        tmo_q <= '0;
      end else if (!fifo_empty_i) begin
        tmo_q <= tmo_q + TW'(1);
      end else begin
        tmo_q <= '0;
      end
    end else if (pop) begin
      cnt_q <= pop_last ? '0 : cnt_q + CW'(1);
    end
  end

  // Two-entry output buffer; entry 0 is the head shown on the stream
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      buf_cnt_q     <= '0;
    end else begin
      if (pull) begin
        buf_data_q[0] <= buf_data_q[1];
        buf_last_q[0] <= buf_last_q[1];
      end
      if (pop) begin
        if (wr_idx) begin
          buf_data_q[1] <= fifo_q_i;
          buf_last_q[1] <= pop_last;
        end else begin
          buf_data_q[0] <= fifo_q_i;
          buf_last_q[0] <= pop_last;
        end
      end
      case ({pop, pull})
        2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural showahead FIFO.
// Inputs change 1ns after a rising edge; outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 5;
  localparam int unsigned BL  = 4;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst;
  logic          ready;
  logic          rdreq;
  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic          busy;

  // Behavioural FIFO feeding the main DUT
  logic [DW-1:0] mem [1024];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic [AW:0]   fifo_usedw;

  assign fifo_q     = mem[rd_ptr[9:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_usedw = (AW+1)'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (srst)       rd_ptr <= wr_ptr;
    else if (rdreq) rd_ptr <= rd_ptr + 1;
  end

  // Second instance with forced bursts disabled, parked on a 3-word FIFO
  logic          rdreq2;
  logic [DW-1:0] data2;
  logic          valid2;
  logic          last2;
  logic          busy2;

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TMO)) u_dut (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_usedw_i(fifo_usedw), .fifo_rdreq_o(rdreq), .data_o(data), .valid_o(valid),
    .last_o(last), .ready_i(ready), .busy_o(busy)
  );

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(0)) u_dut_notmo (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(16'h1234), .fifo_empty_i(1'b0),
    .fifo_usedw_i(6'd3), .fifo_rdreq_o(rdreq2), .data_o(data2), .valid_o(valid2),
    .last_o(last2), .ready_i(1'b1), .busy_o(busy2)
  );

  // Cycle stamps of pops and stream transfers
  int unsigned   cyc = 0;
  int unsigned   pops2 = 0;
  int unsigned   pop_cyc [$];
  logic [DW-1:0] x_data [$];
  logic          x_last [$];
  int unsigned   x_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!srst) begin
      if (rdreq) pop_cyc.push_back(cyc);
      if (valid && ready) begin
        x_data.push_back(data);
        x_last.push_back(last);
        x_cyc.push_back(cyc);
      end
      if (rdreq2) pops2 <= pops2 + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_mon();
    pop_cyc.delete();
    x_data.delete();
    x_last.delete();
    x_cyc.delete();
  endtask

  task automatic test_reset();
    srst  = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (rdreq !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq: got %b expected 0", rdreq); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_tests++; if (last  !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last); end
    n_tests++; if (data  !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_tests++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    at_drive();
    srst = 1'b0;
  endtask

  task automatic test_full_burst();
    int unsigned c0;
    ready = 1'b1;
    clear_mon();
    at_drive();
    c0 = cyc;
    for (int i = 0; i < 4; i++) push_word(16'(16'hA000 + i));
    repeat (6) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_during: got %b expected 1", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    n_tests++;
    if (pop_cyc.size() != 4) begin
      n_fail++; $display("FAIL full_pop_count: got %0d expected 4", pop_cyc.size());
    end else if (pop_cyc[0] != c0 + 1 || pop_cyc[3] != c0 + 4) begin
      n_fail++; $display("FAIL full_pop_cycles: got %0d..%0d expected %0d..%0d", pop_cyc[0], pop_cyc[3], c0 + 1, c0 + 4);
    end
    n_tests++;
    if (x_data.size() != 4) begin
      n_fail++; $display("FAIL full_xfer_count: got %0d expected 4", x_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (x_data[i] !== 16'(16'hA000 + i) || x_last[i] !== (i == 3) || x_cyc[i] != c0 + 2 + i) begin
          n_fail++;
          $display("FAIL full_word%0d: got %h last %b cyc %0d expected %h last %b cyc %0d",
                   i, x_data[i], x_last[i], x_cyc[i], 16'(16'hA000 + i), (i == 3), c0 + 2 + i);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned c0;
    ready = 1'b1;
    clear_mon();
    at_drive();
    c0 = cyc;
    for (int i = 0; i < 3; i++) push_word(16'(16'hB000 + i));
    repeat (16) @(negedge clk);
    n_tests++;
    if (pop_cyc.size() != 3) begin
      n_fail++; $display("FAIL tmo_pop_count: got %0d expected 3", pop_cyc.size());
    end else if (pop_cyc[0] != c0 + 8 || pop_cyc[2] != c0 + 10) begin
      n_fail++; $display("FAIL tmo_pop_cycles: got %0d..%0d expected %0d..%0d", pop_cyc[0], pop_cyc[2], c0 + 8, c0 + 10);
    end
    n_tests++;
    if (x_data.size() != 3) begin
      n_fail++; $display("FAIL tmo_xfer_count: got %0d expected 3", x_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (x_data[i] !== 16'(16'hB000 + i) || x_last[i] !== (i == 2)) begin
          n_fail++;
          $display("FAIL tmo_word%0d: got %h last %b expected %h last %b", i, x_data[i], x_last[i], 16'(16'hB000 + i), (i == 2));
        end
      end
    end
  endtask

  task automatic test_multi_burst();
    int unsigned c0;
    int unsigned exp_pop [9] = '{1, 2, 3, 4, 6, 7, 8, 9, 18};
    int unsigned exp_x   [9] = '{2, 3, 4, 5, 7, 8, 9, 10, 19};
    logic        exp_l   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ready = 1'b1;
    clear_mon();
    at_drive();
    c0 = cyc;
    for (int i = 0; i < 9; i++) push_word(16'(16'hC000 + i));
    repeat (24) @(negedge clk);
    n_tests++;
    if (pop_cyc.size() != 9) begin
      n_fail++; $display("FAIL multi_pop_count: got %0d expected 9", pop_cyc.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (pop_cyc[i] != c0 + exp_pop[i]) begin
          n_fail++; $display("FAIL multi_pop%0d: got cyc %0d expected %0d", i, pop_cyc[i], c0 + exp_pop[i]);
        end
      end
    end
    n_tests++;
    if (x_data.size() != 9) begin
      n_fail++; $display("FAIL multi_xfer_count: got %0d expected 9", x_data.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (x_data[i] !== 16'(16'hC000 + i) || x_last[i] !== exp_l[i] || x_cyc[i] != c0 + exp_x[i]) begin
          n_fail++;
          $display("FAIL multi_word%0d: got %h last %b cyc %0d expected %h last %b cyc %0d",
                   i, x_data[i], x_last[i], x_cyc[i], 16'(16'hC000 + i), exp_l[i], c0 + exp_x[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned c0;
    ready = 1'b0;
    clear_mon();
    at_drive();
    c0 = cyc;
    for (int i = 0; i < 4; i++) push_word(16'(16'hD000 + i));
    repeat (10) @(negedge clk);
    n_tests++; if (pop_cyc.size() != 2) begin n_fail++; $display("FAIL bp_pop_count: got %0d expected 2", pop_cyc.size()); end
    n_tests++; if (rdreq !== 1'b0) begin n_fail++; $display("FAIL bp_rdreq: got %b expected 0", rdreq); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", valid); end
    n_tests++; if (data !== 16'hD000) begin n_fail++; $display("FAIL bp_data: got %h expected d000", data); end
    n_tests++; if (last !== 1'b0) begin n_fail++; $display("FAIL bp_last: got %b expected 0", last); end
    repeat (3) @(negedge clk);
    n_tests++; if (data !== 16'hD000) begin n_fail++; $display("FAIL bp_data_hold: got %h expected d000", data); end
    at_drive();
    ready = 1'b1;
    repeat (8) @(negedge clk);
    n_tests++; if (pop_cyc.size() != 4) begin n_fail++; $display("FAIL bp_pop_total: got %0d expected 4", pop_cyc.size()); end
    n_tests++;
    if (x_data.size() != 4) begin
      n_fail++; $display("FAIL bp_xfer_count: got %0d expected 4", x_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (x_data[i] !== 16'(16'hD000 + i) || x_last[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h last %b expected %h last %b", i, x_data[i], x_last[i], 16'(16'hD000 + i), (i == 3));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    ready = 1'b1;
    clear_mon();
    at_drive();
    for (int i = 0; i < 4; i++) push_word(16'(16'hE000 + i));
    repeat (4) at_drive();
    n_tests++; if (x_data.size() != 2) begin n_fail++; $display("FAIL rst_pre_xfers: got %0d expected 2", x_data.size()); end
    srst = 1'b1;
    @(negedge clk);
    n_tests++; if (rdreq !== 1'b0) begin n_fail++; $display("FAIL rst_no_pop: got %b expected 0", rdreq); end
    at_drive();
    srst = 1'b0;
    @(negedge clk);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", valid); end
    n_tests++; if (last  !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b expected 0", last); end
    n_tests++; if (data  !== 16'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 0000", data); end
    n_tests++; if (rdreq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rdreq: got %b expected 0", rdreq); end
    n_tests++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    repeat (12) @(negedge clk);
    n_tests++; if (x_data.size() != 2) begin n_fail++; $display("FAIL rst_discard: got %0d xfers expected 2", x_data.size()); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] w;
    logic [DW-1:0] pd = '0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          pl = 1'b0;
    int            pushed = 0;
    int            got = 0;
    int            seg = 0;
    int            lasts = 0;
    int            budget = 0;
    while (got < 200 && budget < 10000) begin
      at_drive();
      if (pushed < 200 && (wr_ptr - rd_ptr) < 32 && $urandom_range(0, 3) != 0) begin
        w = 16'($urandom);
        push_word(w);
        exp_q.push_back(w);
        pushed++;
      end
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pv && !pr) begin
        n_tests++;
        if (valid !== 1'b1 || data !== pd || last !== pl) begin
          n_fail++;
          $display("FAIL rnd_stable: got v%b %h l%b expected v1 %h l%b", valid, data, last, pd, pl);
        end
      end
      if (valid && ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_word: got %h expected none", data);
        end else begin
          w = exp_q.pop_front();
          if (data !== w) begin n_fail++; $display("FAIL rnd_order%0d: got %h expected %h", got, data, w); end
        end
        seg++;
        if (last) begin
          lasts++;
          n_tests++;
          if (seg > int'(BL)) begin n_fail++; $display("FAIL rnd_burst_len: got %0d expected <= %0d", seg, BL); end
          seg = 0;
        end
        got++;
      end
      pv = valid; pr = ready; pd = data; pl = last;
      budget++;
    end
    ready = 1'b1;
    n_tests++; if (got != 200) begin n_fail++; $display("FAIL rnd_count: got %0d expected 200", got); end
    n_tests++; if (seg != 0) begin n_fail++; $display("FAIL rnd_final_last: got %0d trailing words expected 0", seg); end
    n_tests++; if (lasts < 50) begin n_fail++; $display("FAIL rnd_last_count: got %0d expected >= 50", lasts); end
  endtask

  task automatic test_timeout_disabled();
    repeat (40) @(negedge clk);
    n_tests++; if (pops2 != 0) begin n_fail++; $display("FAIL notmo_pops: got %0d expected 0", pops2); end
    n_tests++; if (valid2 !== 1'b0) begin n_fail++; $display("FAIL notmo_valid: got %b expected 0", valid2); end
  endtask

  initial begin
    srst  = 1'b1;
    ready = 1'b0;
    test_reset();
    test_full_burst();
    test_timeout();
    test_multi_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    test_timeout_disabled();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
